// File: rtl/mac_out_drain.sv
// rtl/mac_out_drain.sv - snapshot four MAC result lanes and drain them LSB-first as narrow beats
// Optional one-deep capture queue is enabled by defining MAC_DRAIN_CAPTURE_QUEUE_EN.

`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 2
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module mac_out_drain #(
    parameter int ACC_W = `MAC_ACC_WIDTH,
    parameter int OUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`MAC_CONF_WIDTH-1:0] mode,
    input  logic                       capture,
    input  logic [ACC_W-1:0]           in0,
    input  logic [ACC_W-1:0]           in1,
    input  logic [ACC_W-1:0]           in2,
    input  logic [ACC_W-1:0]           in3,
    output logic                       busy,
    output logic [OUT_W-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic [1:0]                 dout_idx,
    output logic                       overrun,
    input  logic                       clr_ovr
);

    localparam int BPL = ACC_W / OUT_W;
    localparam int PW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int SW  = 4 * ACC_W;
    localparam logic [PW-1:0] POS_LAST = PW'(BPL - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]                 state;
    logic [SW-1:0]              shadow;
    logic [`MAC_CONF_WIDTH-1:0] mode_q;
    logic [1:0]                 lane;
    logic [PW-1:0]              pos;

    logic          sending;
    logic          fire;
    logic          lane_end;
    logic          frame_end;
    logic          final_hs;
    logic          mid_capture;
    logic          drop;
    logic [SW-1:0] live;
    logic          res_last;
    logic [1:0]    res_idx;

    // Beat counter is kept as (lane, position-in-lane) so result boundaries need no divider.
    assign sending     = (state == S_SEND);
    assign fire        = sending && dout_ready;
    assign lane_end    = (pos == POS_LAST);
    assign frame_end   = lane_end && (lane == 2'd3);
    assign final_hs    = fire && frame_end;
    assign mid_capture = capture && sending && !final_hs;
    assign live        = {in3, in2, in1, in0};

`ifdef MAC_DRAIN_CAPTURE_QUEUE_EN
    logic [SW-1:0]              q_data;
    logic [`MAC_CONF_WIDTH-1:0] q_mode;
    logic                       q_valid;

    assign drop = mid_capture && q_valid;
`else
    assign drop = mid_capture;
`endif

    always_comb begin
        res_last = lane_end;
        res_idx  = lane;
        if (mode_q == `MAC_QUAD) begin
            res_last = frame_end;
            res_idx  = 2'd0;
        end else if (mode_q == `MAC_DUAL) begin
            res_last = lane_end && lane[0];
            res_idx  = {1'b0, lane[1]};
        end
    end

    assign busy       = sending;
    assign dout_valid = sending;
    assign dout_last  = sending && res_last;
    assign dout_idx   = sending ? res_idx : 2'd0;
    assign dout       = sending ? shadow[int'(lane) * ACC_W + int'(pos) * OUT_W +: OUT_W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            shadow <= '0;
            mode_q <= '0;
            lane   <= 2'd0;
            pos    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        shadow <= live;
                        mode_q <= mode;
                        lane   <= 2'd0;
                        pos    <= '0;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (fire) begin
                        if (frame_end) begin
                            lane <= 2'd0;
                            pos  <= '0;
`ifdef MAC_DRAIN_CAPTURE_QUEUE_EN
                            if (q_valid) begin
                                shadow <= q_data;
                                mode_q <= q_mode;
                            end else if (capture) begin
                                shadow <= live;
                                mode_q <= mode;
                            end else begin
                                state <= S_IDLE;
                            end
`else
                            if (capture) begin
                                shadow <= live;
                                mode_q <= mode;
                            end else begin
                                state <= S_IDLE;
                            end
`endif
                        end else if (lane_end) begin
                            pos  <= '0;
                            lane <= lane + 2'd1;
                        end else begin
                            pos <= pos + PW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAC_DRAIN_CAPTURE_QUEUE_EN
    // On the final handshake a queued frame goes first; a coincident capture then refills the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_mode  <= '0;
        end else if (final_hs) begin
            q_valid <= q_valid && capture;
            if (q_valid && capture) begin
                q_data <= live;
                q_mode <= mode;
            end
        end else if (mid_capture && !q_valid) begin
            q_valid <= 1'b1;
            q_data  <= live;
            q_mode  <= mode;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_out_drain.sv
// tb/tb_mac_out_drain.sv - scoreboard bench for mac_out_drain (ACC_W=16, OUT_W=8)

`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 2
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module tb_mac_out_drain;

    localparam int ACC_W = 16;
    localparam int OUT_W = 8;
    localparam logic [`MAC_CONF_WIDTH-1:0] M_SINGLE = '0;
    localparam logic [`MAC_CONF_WIDTH-1:0] M_DUAL   = `MAC_DUAL;
    localparam logic [`MAC_CONF_WIDTH-1:0] M_QUAD   = `MAC_QUAD;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [`MAC_CONF_WIDTH-1:0] mode;
    logic                       capture;
    logic [ACC_W-1:0]           in0, in1, in2, in3;
    logic                       busy;
    logic [OUT_W-1:0]           dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic                       dout_last;
    logic [1:0]                 dout_idx;
    logic                       overrun;
    logic                       clr_ovr;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [1:0] idx;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    hs      = 0;

    mac_out_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .capture    (capture),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .dout_idx   (dout_idx),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected beats straight from the result-size rule: last = (k+1)%RS==0, idx = k/RS.
    task automatic push_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [`MAC_CONF_WIDTH-1:0] m);
        logic [63:0] f;
        int          rs;
        beat_t       e;
        f  = {d, c, b, a};
        rs = (m == M_QUAD) ? 8 : ((m == M_DUAL) ? 4 : 2);
        for (int k = 0; k < 8; k++) begin
            e.d    = f[k*8 +: 8];
            e.last = ((k + 1) % rs == 0);
            e.idx  = 2'(k / rs);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d, input logic [`MAC_CONF_WIDTH-1:0] m, input bit accept);
        in0 = a; in1 = b; in2 = c; in3 = d; mode = m;
        capture = 1'b1;
        if (accept) push_frame(a, b, c, d, m);
        tick();
        capture = 1'b0;
    endtask

    task automatic wait_hs(input int target, input string nm);
        for (int i = 0; i < 200 && hs < target; i++) tick();
        chk(nm, hs, target);
    endtask

    always @(posedge clk) begin
        if (rst === 1'b1 && dout_valid && dout_ready) hs++;
    end

    // Monitor: any presented beat must match the scoreboard head; it is popped on acceptance.
    always @(negedge clk) begin
        if (rst === 1'b1 && dout_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got dout=%0h with empty scoreboard", dout);
            end else if ({dout, dout_last, dout_idx} !== sb[0]) begin
                n_fail++;
                $display("FAIL beat: got d=%0h last=%0d idx=%0d expected d=%0h last=%0d idx=%0d",
                         dout, dout_last, dout_idx, sb[0].d, sb[0].last, sb[0].idx);
            end
            if (dout_ready && sb.size() != 0) void'(sb.pop_front());
        end
    end

    initial begin
        int  base;
        time t0;
        rst = 1'b0; mode = M_SINGLE; capture = 1'b0; clr_ovr = 1'b0; dout_ready = 1'b1;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_idx", dout_idx, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: single mode, continuous ready
        base = hs;
        cap(16'h1100, 16'h3322, 16'h5544, 16'h7766, M_SINGLE, 1'b1);
        chk("t1_latency_valid", dout_valid, 1);
        chk("t1_latency_busy", busy, 1);
        chk("t1_first_byte", dout, 8'h00);
        repeat (8) tick();
        chk("t1_beats_in_8", hs, base + 8);
        chk("t1_busy_fall", busy, 0);

        // 2: quad mode, ready toggling 1010...
        base = hs;
        cap(16'h1100, 16'h3322, 16'h5544, 16'h7766, M_QUAD, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (hs >= base + 8) break;
            dout_ready = ~dout_ready;
        end
        chk("t2_done", hs, base + 8);
        chk("t2_busy_fall", busy, 0);
        dout_ready = 1'b1;
        tick();

        // 3: dual mode, live mode switched to single mid-frame
        base = hs;
        cap(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, M_DUAL, 1'b1);
        wait_hs(base + 2, "t3_beat2");
        mode = M_SINGLE;
        wait_hs(base + 8, "t3_done");
        chk("t3_busy_fall", busy, 0);

        // 4: mid-frame capture dropped (no queue), then capture on the final handshake
        base = hs;
        cap(16'h2211, 16'h4433, 16'h6655, 16'h8877, M_SINGLE, 1'b1);
        wait_hs(base + 3, "t4_beat3");
`ifndef MAC_DRAIN_CAPTURE_QUEUE_EN
        cap(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, M_QUAD, 1'b0);
        chk("t4_overrun_set", overrun, 1);
        chk("t4_stream_unaffected", hs, base + 4);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("t4_overrun_clr", overrun, 0);
`endif
        wait_hs(base + 7, "t4_beat7");
        cap(16'h0102, 16'h0304, 16'h0506, 16'h0708, M_DUAL, 1'b1);
        chk("t4_no_bubble_hs", hs, base + 8);
        chk("t4_no_bubble_valid", dout_valid, 1);
        chk("t4_no_overrun", overrun, 0);
        wait_hs(base + 16, "t4_done");
        chk("t4_busy_fall", busy, 0);

`ifdef MAC_DRAIN_CAPTURE_QUEUE_EN
        // 5: queued capture plays back-to-back, second mid-frame capture overruns
        base = hs;
        cap(16'h1010, 16'h2020, 16'h3030, 16'h4040, M_SINGLE, 1'b1);
        t0 = $time;
        wait_hs(base + 2, "t5_beat2");
        cap(16'h5A5B, 16'h6C6D, 16'h7E7F, 16'h8081, M_QUAD, 1'b1);
        wait_hs(base + 4, "t5_beat4");
        cap(16'h9999, 16'h8888, 16'h7777, 16'h6666, M_DUAL, 1'b0);
        chk("t5_overrun_set", overrun, 1);
        wait_hs(base + 16, "t5_done");
        chk("t5_back_to_back", int'(($time - t0) / 10), 16);
        chk("t5_busy_fall", busy, 0);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("t5_overrun_clr", overrun, 0);
`else
        t0 = $time;
`endif

        // 6: asynchronous reset mid-frame
        base = hs;
        cap(16'h3C3C, 16'h5A5A, 16'h6969, 16'h9696, M_SINGLE, 1'b1);
        wait_hs(base + 4, "t6_beat4");
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("t6_async_busy", busy, 0);
        chk("t6_async_valid", dout_valid, 0);
        chk("t6_async_dout", dout, 0);
        chk("t6_async_last", dout_last, 0);
        chk("t6_async_idx", dout_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_valid", dout_valid, 0);
        chk("t6_no_resume", hs, base + 4);
        base = hs;
        cap(16'hF1E2, 16'hD3C4, 16'hB5A6, 16'h9788, M_QUAD, 1'b1);
        wait_hs(base + 8, "t6_recover");
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
